// File: rtl/rc4_decrypt_if.sv
// Memory-side bus of the RC4 decrypt stage: S-RAM, ciphertext ROM and plaintext RAM.
// The master side drives the registered addresses/write strobes and receives read data.
interface rc4_decrypt_if #(
   parameter int MSG_AW = 5
) ();
   logic [7:0]        s_address;
   logic [7:0]        s_data;
   logic              s_wren;
   logic [7:0]        s_q;
   logic [MSG_AW-1:0] rom_address;
   logic [7:0]        rom_q;
   logic [MSG_AW-1:0] d_address;
   logic [7:0]        d_data;
   logic              d_wren;

   modport master (
      output s_address, s_data, s_wren, rom_address, d_address, d_data, d_wren,
      input  s_q, rom_q
   );

   modport slave (
      input  s_address, s_data, s_wren, rom_address, d_address, d_data, d_wren,
      output s_q, rom_q
   );
endinterface

// File: rtl/rc4_decrypt.sv
// RC4 keystream generation over a pre-shuffled S-RAM; XORs each keystream byte
// with the ciphertext ROM and writes plaintext to the decrypted-message RAM.
module rc4_decrypt #(
   parameter int MSG_LEN = 32,
   parameter int MSG_AW  = 5
) (
   input  logic           clk,
   input  logic           reset_n,
   input  logic           start,
   output logic           finish,
   rc4_decrypt_if.master  bus
);
   typedef enum logic [3:0] {
      IDLE, INC_I, WAIT_SI, READ_SI, SET_J, WAIT_SJ, READ_SJ, WRITE_I,
      WRITE_J, SET_F, WAIT_F, READ_F, WRITE_D, NEXT, DONE
   } state_t;

   state_t            state, state_nx;
   logic [7:0]        i, j, si, sj, f, enc;
   logic [7:0]        i_nx, j_nx, si_nx, sj_nx, f_nx, enc_nx;
   logic [MSG_AW-1:0] k, k_nx;
   logic [7:0]        s_addr, s_addr_nx, s_dat, s_dat_nx;
   logic              s_we, s_we_nx, d_we, d_we_nx, fin, fin_nx;
   logic [MSG_AW-1:0] rom_addr, rom_addr_nx, d_addr, d_addr_nx;
   logic [7:0]        d_dat, d_dat_nx;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state    <= IDLE;
         i        <= '0;
         j        <= '0;
         si       <= '0;
         sj       <= '0;
         f        <= '0;
         enc      <= '0;
         k        <= '0;
         s_addr   <= '0;
         s_dat    <= '0;
         s_we     <= 1'b0;
         rom_addr <= '0;
         d_addr   <= '0;
         d_dat    <= '0;
         d_we     <= 1'b0;
         fin      <= 1'b0;
      end else begin
         state    <= state_nx;
         i        <= i_nx;
         j        <= j_nx;
         si       <= si_nx;
         sj       <= sj_nx;
         f        <= f_nx;
         enc      <= enc_nx;
         k        <= k_nx;
         s_addr   <= s_addr_nx;
         s_dat    <= s_dat_nx;
         s_we     <= s_we_nx;
         rom_addr <= rom_addr_nx;
         d_addr   <= d_addr_nx;
         d_dat    <= d_dat_nx;
         d_we     <= d_we_nx;
         fin      <= fin_nx;
      end
   end

   // Memories have a 1-cycle read latency behind the registered address,
   // hence one WAIT state between each address set and its data capture.
   always_comb begin
      state_nx    = state;
      i_nx        = i;
      j_nx        = j;
      si_nx       = si;
      sj_nx       = sj;
      f_nx        = f;
      enc_nx      = enc;
      k_nx        = k;
      s_addr_nx   = s_addr;
      s_dat_nx    = s_dat;
      s_we_nx     = s_we;
      rom_addr_nx = rom_addr;
      d_addr_nx   = d_addr;
      d_dat_nx    = d_dat;
      d_we_nx     = d_we;
      fin_nx      = fin;
      case (state)
         IDLE: if (start) begin
            i_nx     = '0;
            j_nx     = '0;
            k_nx     = '0;
            state_nx = INC_I;
         end
         INC_I: begin
            i_nx      = i + 8'd1;
            s_addr_nx = i + 8'd1;
            state_nx  = WAIT_SI;
         end
         WAIT_SI: state_nx = READ_SI;
         READ_SI: begin
            si_nx    = bus.s_q;
            j_nx     = j + bus.s_q;
            state_nx = SET_J;
         end
         SET_J: begin
            s_addr_nx = j;
            state_nx  = WAIT_SJ;
         end
         WAIT_SJ: state_nx = READ_SJ;
         READ_SJ: begin
            sj_nx    = bus.s_q;
            state_nx = WRITE_I;
         end
         WRITE_I: begin
            s_addr_nx = i;
            s_dat_nx  = sj;
            s_we_nx   = 1'b1;
            state_nx  = WRITE_J;
         end
         // When i==j this second write lands last, and si==sj, so S stays correct.
         WRITE_J: begin
            s_addr_nx = j;
            s_dat_nx  = si;
            s_we_nx   = 1'b1;
            state_nx  = SET_F;
         end
         SET_F: begin
            s_we_nx     = 1'b0;
            s_addr_nx   = si + sj;
            rom_addr_nx = k;
            state_nx    = WAIT_F;
         end
         WAIT_F: state_nx = READ_F;
         READ_F: begin
            f_nx     = bus.s_q;
            enc_nx   = bus.rom_q;
            state_nx = WRITE_D;
         end
         WRITE_D: begin
            d_addr_nx = k;
            d_dat_nx  = f ^ enc;
            d_we_nx   = 1'b1;
            state_nx  = NEXT;
         end
         NEXT: begin
            d_we_nx = 1'b0;
            if (k == MSG_AW'(MSG_LEN - 1)) begin
               fin_nx   = 1'b1;
               state_nx = DONE;
            end else begin
               k_nx     = k + MSG_AW'(1);
               state_nx = INC_I;
            end
         end
         DONE: if (!start) begin
            fin_nx   = 1'b0;
            state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   assign finish          = fin;
   assign bus.s_address   = s_addr;
   assign bus.s_data      = s_dat;
   assign bus.s_wren      = s_we;
   assign bus.rom_address = rom_addr;
   assign bus.d_address   = d_addr;
   assign bus.d_data      = d_dat;
   assign bus.d_wren      = d_we;
endmodule

// File: tb/tb_rc4_decrypt.sv
// Bench for rc4_decrypt: behavioural memories, golden RC4 model feeding a
// scoreboard of expected plaintext writes, plus timing/strobe accounting.
module tb_rc4_decrypt;
   localparam int MSG_LEN = 32;
   localparam int MSG_AW  = 5;
   localparam int BYTE_CYC = 13;

   typedef struct {
      logic [MSG_AW-1:0] a;
      logic [7:0]        d;
   } exp_t;

   logic clk = 1'b0;
   logic reset_n;
   logic start;
   logic finish;

   rc4_decrypt_if #(.MSG_AW(MSG_AW)) bus ();

   rc4_decrypt #(.MSG_LEN(MSG_LEN), .MSG_AW(MSG_AW)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .start   (start),
      .finish  (finish),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   logic [7:0] smem [256];
   logic [7:0] rom  [MSG_LEN];
   logic [7:0] dmem [MSG_LEN];
   logic       ld_en;
   logic [7:0] ld_addr, ld_dat;

   // Synchronous memories: address latched at the edge, data valid after it.
   always @(posedge clk) begin
      if (ld_en) smem[ld_addr] <= ld_dat;
      else if (bus.s_wren) smem[bus.s_address] <= bus.s_data;
      bus.s_q   <= smem[bus.s_address];
      bus.rom_q <= rom[bus.rom_address];
      if (bus.d_wren) dmem[bus.d_address] <= bus.d_data;
   end

   logic [7:0] ms [256];
   exp_t sb [$];
   int n_cmp = 0;
   int n_err = 0;
   int sw_cnt = 0, dw_cnt = 0, ov_cnt = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic load_s();
      for (int x = 0; x < 256; x++) begin
         @(negedge clk);
         ld_en   = 1'b1;
         ld_addr = 8'(x);
         ld_dat  = ms[x];
      end
      @(negedge clk);
      ld_en = 1'b0;
   endtask

   task automatic ksa(input int klen);
      logic [7:0] key [16];
      logic [7:0] jj, t;
      for (int x = 0; x < klen; x++) key[x] = 8'($urandom);
      for (int x = 0; x < 256; x++) ms[x] = 8'(x);
      jj = 8'd0;
      for (int x = 0; x < 256; x++) begin
         jj = jj + ms[x] + key[x % klen];
         t = ms[x]; ms[x] = ms[jj]; ms[jj] = t;
      end
   endtask

   // Golden PRGA over the model S; pushes every expected plaintext write.
   task automatic model_pass();
      logic [7:0] ii, jj, t, idx;
      exp_t e;
      ii = 8'd0; jj = 8'd0;
      for (int kk = 0; kk < MSG_LEN; kk++) begin
         ii = ii + 8'd1;
         jj = jj + ms[ii];
         t = ms[ii]; ms[ii] = ms[jj]; ms[jj] = t;
         idx = ms[ii] + ms[jj];
         e.a = MSG_AW'(kk);
         e.d = ms[idx] ^ rom[kk];
         sb.push_back(e);
      end
   endtask

   task automatic sample();
      exp_t e;
      if (bus.s_wren) sw_cnt++;
      if (bus.s_wren && bus.d_wren) ov_cnt++;
      if (bus.d_wren) begin
         dw_cnt++;
         if (sb.size() == 0) chk("sb_underflow", 64'd1, 64'd0);
         else begin
            e = sb.pop_front();
            chk("d_addr", 64'(bus.d_address), 64'(e.a));
            chk("d_data", 64'(bus.d_data), 64'(e.d));
         end
      end
   endtask

   function automatic logic [63:0] outs();
      return 64'({finish, bus.s_address, bus.s_data, bus.s_wren,
                  bus.rom_address, bus.d_address, bus.d_data, bus.d_wren});
   endfunction

   // rel_reset: the pass is launched by releasing reset with start already high.
   task automatic run_pass(input string tag, input bit rel_reset,
                           input int glitch_at, input int abort_at);
      int n, sw0, dw0, ov0, bad;
      bit done;
      model_pass();
      sw0 = sw_cnt; dw0 = dw_cnt; ov0 = ov_cnt;
      @(negedge clk);
      if (rel_reset) reset_n = 1'b1;
      else start = 1'b1;
      @(posedge clk);
      n = 0; done = 1'b0;
      while (!done && n < 2000) begin
         @(posedge clk);
         n++;
         #1;
         sample();
         if (finish) done = 1'b1;
         if (glitch_at > 0 && n == glitch_at) start = 1'b0;
         if (glitch_at > 0 && n == glitch_at + 3) start = 1'b1;
         if (abort_at > 0 && n == abort_at) begin
            reset_n = 1'b0;
            #1;
            chk({tag, "_abort_outs"}, outs(), 64'd0);
            sw0 = sw_cnt; dw0 = dw_cnt;
            start = 1'b0;
            repeat (5) begin
               @(posedge clk); #1; sample();
            end
            chk({tag, "_abort_writes"}, 64'((sw_cnt - sw0) + (dw_cnt - dw0)), 64'd0);
            chk({tag, "_abort_left"}, 64'(sb.size()), 64'(MSG_LEN - 20));
            sb.delete();
            return;
         end
      end
      chk({tag, "_cycles"}, 64'(n), 64'(BYTE_CYC * MSG_LEN));
      chk({tag, "_s_wren"}, 64'(sw_cnt - sw0), 64'(2 * MSG_LEN));
      chk({tag, "_d_wren"}, 64'(dw_cnt - dw0), 64'(MSG_LEN));
      chk({tag, "_overlap"}, 64'(ov_cnt - ov0), 64'd0);
      repeat (3) begin
         @(posedge clk); #1; sample();
      end
      chk({tag, "_fin_hold"}, 64'(finish), 64'd1);
      @(negedge clk);
      start = 1'b0;
      @(posedge clk); #1;
      chk({tag, "_fin_clear"}, 64'(finish), 64'd0);
      chk({tag, "_sb_left"}, 64'(sb.size()), 64'd0);
      bad = 0;
      for (int x = 0; x < 256; x++) if (smem[x] !== ms[x]) bad++;
      chk({tag, "_s_final"}, 64'(bad), 64'd0);
   endtask

   initial begin
      int sw0, dw0;
      reset_n = 1'b0;
      start   = 1'b1;
      ld_en   = 1'b0;
      ld_addr = '0;
      ld_dat  = '0;

      // Reset held with start high: identity S, zero ciphertext.
      for (int x = 0; x < 256; x++) ms[x] = 8'(x);
      for (int x = 0; x < MSG_LEN; x++) rom[x] = 8'h00;
      load_s();
      sw0 = sw_cnt; dw0 = dw_cnt;
      repeat (5) begin
         @(posedge clk); #1; sample();
      end
      chk("rst_outs", outs(), 64'd0);
      chk("rst_writes", 64'((sw_cnt - sw0) + (dw_cnt - dw0)), 64'd0);
      run_pass("ident", 1'b1, 0, 0);
      chk("ident_p0", 64'(dmem[0]), 64'h02);
      chk("ident_p1", 64'(dmem[1]), 64'h05);
      chk("ident_p2", 64'(dmem[2]), 64'h07);

      // All-0xFF S exercises j wraparound; every keystream byte is 0xFF.
      for (int x = 0; x < 256; x++) ms[x] = 8'hFF;
      load_s();
      run_pass("allff", 1'b0, 0, 0);
      chk("allff_p1", 64'(dmem[1]), 64'hFF);
      chk("allff_p31", 64'(dmem[MSG_LEN-1]), 64'hFF);

      // Start glitch at byte 10, then reset at byte 20.
      ksa(5);
      for (int x = 0; x < MSG_LEN; x++) rom[x] = 8'($urandom);
      load_s();
      run_pass("abort", 1'b0, 10 * BYTE_CYC, 20 * BYTE_CYC + 5);

      // Restart after abort with a fresh KSA-shuffled S and random ciphertext.
      ksa(13);
      for (int x = 0; x < MSG_LEN; x++) rom[x] = 8'($urandom);
      load_s();
      start = 1'b1;
      run_pass("rand", 1'b1, 0, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
